// File: rtl/c7blsu_ctl.sv
// Load/store unit control: latches one E-stage request, flags misaligned
// addresses in LS1, runs a single bus transfer and reports completion in LS3.
module c7blsu_ctl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lsu_vld_e,
  input  logic        lsu_wr_e,
  input  logic [1:0]  lsu_size_e,
  input  logic        lsu_unsigned_e,
  input  logic [31:0] lsu_addr_e,
  input  logic [31:0] lsu_wdata_e,
  output logic        lsu_except_ale_ls1,
  output logic        lsu_data_valid_ls3,
  output logic        lsu_wr_fin_ls3,
  output logic [31:0] lsu_rdata_ls3,
  output logic        lsu_busy,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LS1  = 2'd1,
    REQ  = 2'd2,
    LS3  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  state_t      r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mis;

  logic        r_ale;
  logic        r_data_valid;
  logic        r_wr_fin;
  logic [31:0] r_rdata_ls3;
  logic        r_bus_req;
  logic        r_bus_wr;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;

  logic        w_mis_e;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rdata_ext;

  // Alignment is judged on the incoming request so the ALE pulse can be
  // registered straight into the LS1 cycle.
  always_comb begin
    w_mis_e = 1'b0;
    case (lsu_size_e)
      SZ_BYTE: w_mis_e = 1'b0;
      SZ_HALF: w_mis_e = lsu_addr_e[0];
      default: w_mis_e = |lsu_addr_e[1:0];
    endcase
  end

  always_comb begin
    w_wstrb     = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_wstrb     = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_wstrb     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_wstrb     = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_rdata_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      SZ_HALF: w_rdata_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_rdata_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_uns        <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_mis        <= 1'b0;
      r_ale        <= 1'b0;
      r_data_valid <= 1'b0;
      r_wr_fin     <= 1'b0;
      r_rdata_ls3  <= 32'd0;
      r_bus_req    <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_bus_addr   <= 32'd0;
      r_bus_wstrb  <= 4'd0;
      r_bus_wdata  <= 32'd0;
    end else begin
      r_ale        <= 1'b0;
      r_data_valid <= 1'b0;
      r_wr_fin     <= 1'b0;
      case (r_state)
        IDLE, LS3: begin
          r_rdata_ls3 <= 32'd0;
          if (lsu_vld_e) begin
            r_wr    <= lsu_wr_e;
            r_size  <= lsu_size_e;
            r_uns   <= lsu_unsigned_e;
            r_addr  <= lsu_addr_e;
            r_wdata <= lsu_wdata_e;
            r_mis   <= w_mis_e;
            r_ale   <= w_mis_e;
            r_state <= LS1;
          end else begin
            r_state <= IDLE;
          end
        end
        LS1: begin
          if (r_mis) begin
            r_state <= IDLE;
          end else begin
            r_state     <= REQ;
            r_bus_req   <= 1'b1;
            r_bus_wr    <= r_wr;
            r_bus_addr  <= {r_addr[31:2], 2'b00};
            r_bus_wstrb <= r_wr ? w_wstrb : 4'd0;
            r_bus_wdata <= r_wr ? w_wdata_rep : 32'd0;
          end
        end
        REQ: begin
          // Bus fields stay frozen until the acknowledge; no timeout.
          if (bus_ack) begin
            r_state      <= LS3;
            r_bus_req    <= 1'b0;
            r_bus_wr     <= 1'b0;
            r_bus_addr   <= 32'd0;
            r_bus_wstrb  <= 4'd0;
            r_bus_wdata  <= 32'd0;
            r_data_valid <= ~r_wr;
            r_wr_fin     <= r_wr;
            r_rdata_ls3  <= r_wr ? 32'd0 : w_rdata_ext;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lsu_except_ale_ls1 = r_ale;
  assign lsu_data_valid_ls3 = r_data_valid;
  assign lsu_wr_fin_ls3     = r_wr_fin;
  assign lsu_rdata_ls3      = r_rdata_ls3;
  assign lsu_busy           = (r_state != IDLE);
  assign bus_req            = r_bus_req;
  assign bus_wr             = r_bus_wr;
  assign bus_addr           = r_bus_addr;
  assign bus_wstrb          = r_bus_wstrb;
  assign bus_wdata          = r_bus_wdata;

endmodule

// File: tb/tb_c7blsu_ctl.sv
// Directed and randomized bench for c7blsu_ctl, checked against a
// transaction-level model of the load/store rules.
module tb_c7blsu_ctl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lsu_vld_e;
  logic        lsu_wr_e;
  logic [1:0]  lsu_size_e;
  logic        lsu_unsigned_e;
  logic [31:0] lsu_addr_e;
  logic [31:0] lsu_wdata_e;
  logic        lsu_except_ale_ls1;
  logic        lsu_data_valid_ls3;
  logic        lsu_wr_fin_ls3;
  logic [31:0] lsu_rdata_ls3;
  logic        lsu_busy;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  c7blsu_ctl dut (
    .clk                (clk),
    .resetn             (resetn),
    .lsu_vld_e          (lsu_vld_e),
    .lsu_wr_e           (lsu_wr_e),
    .lsu_size_e         (lsu_size_e),
    .lsu_unsigned_e     (lsu_unsigned_e),
    .lsu_addr_e         (lsu_addr_e),
    .lsu_wdata_e        (lsu_wdata_e),
    .lsu_except_ale_ls1 (lsu_except_ale_ls1),
    .lsu_data_valid_ls3 (lsu_data_valid_ls3),
    .lsu_wr_fin_ls3     (lsu_wr_fin_ls3),
    .lsu_rdata_ls3      (lsu_rdata_ls3),
    .lsu_busy           (lsu_busy),
    .bus_req            (bus_req),
    .bus_wr             (bus_wr),
    .bus_addr           (bus_addr),
    .bus_wstrb          (bus_wstrb),
    .bus_wdata          (bus_wdata),
    .bus_ack            (bus_ack),
    .bus_rdata          (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rules, stated as plain arithmetic on the transaction.
  function automatic bit model_mis(input bit [1:0] size, input bit [31:0] addr);
    if (size == 0) return 1'b0;
    if (size == 1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic bit [3:0] model_wstrb(input bit [1:0] size, input bit [31:0] addr);
    if (size == 0) return 4'(1 << (addr % 4));
    if (size == 1) return ((addr / 2) % 2) != 0 ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic bit [31:0] model_wdata(input bit [1:0] size, input bit [31:0] wd);
    if (size == 0) return (wd % 256) * 32'h0101_0101;
    if (size == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic bit [31:0] model_load(input bit [1:0] size, input bit uns,
                                           input bit [31:0] addr, input bit [31:0] rd);
    bit [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * (addr % 4))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rd >> (16 * ((addr / 2) % 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic check_quiet_outputs(input string tag);
    chk({tag, ".ale"},   32'(lsu_except_ale_ls1), 32'd0);
    chk({tag, ".dv"},    32'(lsu_data_valid_ls3), 32'd0);
    chk({tag, ".wf"},    32'(lsu_wr_fin_ls3),     32'd0);
    chk({tag, ".rdata"}, lsu_rdata_ls3,           32'd0);
    chk({tag, ".req"},   32'(bus_req),            32'd0);
    chk({tag, ".wr"},    32'(bus_wr),             32'd0);
    chk({tag, ".addr"},  bus_addr,                32'd0);
    chk({tag, ".wstrb"}, 32'(bus_wstrb),          32'd0);
    chk({tag, ".wdata"}, bus_wdata,               32'd0);
  endtask

  // Called with the current cycle being cycle 0 of the new operation. With
  // chain set it returns during the LS3 cycle so the caller can issue again.
  task automatic do_op(input string tag, input bit wr, input bit [1:0] size, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wd, input int waits,
                       input bit [31:0] rd, input bit poke, input bit chain);
    bit mis;
    mis = model_mis(size, addr);
    lsu_vld_e      = 1'b1;
    lsu_wr_e       = wr;
    lsu_size_e     = size;
    lsu_unsigned_e = uns;
    lsu_addr_e     = addr;
    lsu_wdata_e    = wd;
    bus_ack        = 1'($urandom % 2);
    bus_rdata      = $urandom;
    step();
    // cycle 1
    chk({tag, ".ale1"},  32'(lsu_except_ale_ls1), 32'(mis));
    chk({tag, ".busy1"}, 32'(lsu_busy),           32'd1);
    chk({tag, ".req1"},  32'(bus_req),            32'd0);
    chk({tag, ".dv1"},   32'(lsu_data_valid_ls3), 32'd0);
    chk({tag, ".wf1"},   32'(lsu_wr_fin_ls3),     32'd0);
    lsu_vld_e = 1'b0;
    bus_ack   = 1'($urandom % 2);
    step();
    if (mis) begin
      chk({tag, ".busy_ale"}, 32'(lsu_busy), 32'd0);
      check_quiet_outputs({tag, ".after_ale"});
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      chk({tag, ".req"},   32'(bus_req),   32'd1);
      chk({tag, ".bwr"},   32'(bus_wr),    32'(wr));
      chk({tag, ".baddr"}, bus_addr,       addr - (addr % 4));
      chk({tag, ".wstrb"}, 32'(bus_wstrb), wr ? 32'(model_wstrb(size, addr)) : 32'd0);
      if (wr) chk({tag, ".bwdata"}, bus_wdata, model_wdata(size, wd));
      chk({tag, ".pulses"}, {29'd0, lsu_except_ale_ls1, lsu_data_valid_ls3, lsu_wr_fin_ls3}, 32'd0);
      if (poke) begin
        lsu_vld_e      = 1'b1;
        lsu_wr_e       = ~wr;
        lsu_size_e     = 2'($urandom);
        lsu_unsigned_e = ~uns;
        lsu_addr_e     = $urandom;
        lsu_wdata_e    = $urandom;
      end
      bus_ack   = (w == waits);
      bus_rdata = (w == waits) ? rd : $urandom;
      step();
    end
    // LS3
    lsu_vld_e = 1'b0;
    bus_ack   = 1'($urandom % 2);
    bus_rdata = $urandom;
    chk({tag, ".dv"},    32'(lsu_data_valid_ls3), 32'(!wr));
    chk({tag, ".wf"},    32'(lsu_wr_fin_ls3),     32'(wr));
    chk({tag, ".rdata"}, lsu_rdata_ls3,           wr ? 32'd0 : model_load(size, uns, addr, rd));
    chk({tag, ".ale3"},  32'(lsu_except_ale_ls1), 32'd0);
    chk({tag, ".req3"},  32'(bus_req),            32'd0);
    chk({tag, ".busy3"}, 32'(lsu_busy),           32'd1);
    if (chain) return;
    step();
    chk({tag, ".busy_end"}, 32'(lsu_busy), 32'd0);
    check_quiet_outputs({tag, ".end"});
  endtask

  initial begin
    bit [1:0]  r_size;
    bit [31:0] r_addr;
    resetn = 1'b0;
    lsu_vld_e = 1'b0; lsu_wr_e = 1'b0; lsu_size_e = 2'd0; lsu_unsigned_e = 1'b0;
    lsu_addr_e = 32'd0; lsu_wdata_e = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    step();
    step();
    chk("reset.busy", 32'(lsu_busy), 32'd0);
    check_quiet_outputs("reset");
    resetn = 1'b1;

    // First cycle after release accepts a request.
    do_op("ldw_1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_op("ldb_s",    1'b0, 2'd0, 1'b0, 32'h1003, 32'd0, 0, 32'h80FF_FFFF, 1'b0, 1'b0);
    do_op("ldb_u",    1'b0, 2'd0, 1'b1, 32'h1003, 32'd0, 0, 32'h80FF_FFFF, 1'b0, 1'b0);
    do_op("sth_2002", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 3, 32'd0, 1'b0, 1'b0);
    do_op("ale_3001", 1'b0, 2'd2, 1'b0, 32'h3001, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    do_op("ale_half", 1'b1, 2'd1, 1'b0, 32'h3005, 32'h1234, 0, 32'd0, 1'b0, 1'b0);
    do_op("ale_rsv",  1'b0, 2'd3, 1'b0, 32'h3002, 32'd0, 0, 32'd0, 1'b0, 1'b0);
    do_op("ldh_hi_s", 1'b0, 2'd1, 1'b0, 32'h4002, 32'd0, 1, 32'h8001_7FFF, 1'b0, 1'b0);
    do_op("stb_lane", 1'b1, 2'd0, 1'b0, 32'h4001, 32'h0000_005A, 0, 32'd0, 1'b0, 1'b0);

    // Back-to-back with a request poked during REQ, then a chained issue.
    do_op("b2b_a", 1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 2, 32'h0123_4567, 1'b1, 1'b1);
    do_op("b2b_b", 1'b1, 2'd3, 1'b0, 32'h5004, 32'hCAFE_F00D, 0, 32'd0, 1'b0, 1'b1);
    do_op("b2b_c", 1'b0, 2'd1, 1'b1, 32'h5006, 32'd0, 0, 32'hFFFF_0000, 1'b0, 1'b0);

    // Reset during a bus wait.
    lsu_vld_e = 1'b1; lsu_wr_e = 1'b0; lsu_size_e = 2'd2; lsu_addr_e = 32'h40; bus_ack = 1'b0;
    step();
    lsu_vld_e = 1'b0;
    step();
    chk("rst_mid.req_before", 32'(bus_req), 32'd1);
    step();
    resetn = 1'b0;
    #1;
    chk("rst_mid.req_async",  32'(bus_req),  32'd0);
    chk("rst_mid.busy_async", 32'(lsu_busy), 32'd0);
    check_quiet_outputs("rst_mid");
    bus_ack = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid.no_dv", 32'(lsu_data_valid_ls3), 32'd0);
      chk("rst_mid.no_wf", 32'(lsu_wr_fin_ls3),     32'd0);
      chk("rst_mid.idle",  32'(lsu_busy),           32'd0);
      step();
    end
    bus_ack = 1'b0;
    do_op("post_rst", 1'b0, 2'd0, 1'b0, 32'h0000_0042, 32'd0, 1, 32'h00F0_0000, 1'b0, 1'b0);

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      r_size = 2'($urandom);
      r_addr = $urandom;
      if ($urandom % 3 != 0) r_addr = r_addr - (r_addr % 4) + ((r_size == 0) ? (r_addr % 4) : 0);
      do_op($sformatf("rnd%0d", i), 1'($urandom), r_size, 1'($urandom), r_addr, $urandom,
            int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom));
    end
    lsu_vld_e = 1'b0;
    step();
    step();
    chk("final.busy", 32'(lsu_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
